// File: rtl/mux_seq_pkg.sv
// Shared constants and helpers for the analog mux sequencer.
// State codes are plain 2-bit constants so legacy netlists and probes keep their encoding.
package mux_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t BREAK = 2'd1;
  localparam state_t HOLD  = 2'd2;

  localparam int DEF_DEAD_CYCLES = 2;
  localparam int DEF_DWELL_W     = 8;

  // A select is usable only if it names an existing channel.
  function automatic logic sel_valid(input int unsigned sel, input int unsigned n);
    return sel < n;
  endfunction

endpackage

// File: rtl/mux_gate_decoder.sv
// Registered binary-to-complementary-one-hot decoder for the transmission-gate mux.
// gate_p is always the exact complement of gate_n, including during reset.
module mux_gate_decoder #(
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  gate_n,
  output logic [N_CH-1:0]  gate_p
);

  logic [N_CH-1:0] onehot;

  assign onehot = N_CH'(1) << sel;

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      gate_n <= '0;
      gate_p <= '1;
    end else begin
      gate_n <= onehot;
      gate_p <= ~onehot;
    end
  end

endmodule

// File: rtl/analog_mux_sequencer.sv
// Break-before-make channel sequencer for an N-channel analog mux, manual or scan.
// Outputs are registered from the FSM state, so they trail the state by one cycle.
module analog_mux_sequencer
  import mux_seq_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SEL_W       = $clog2(N_CH),
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES,
  parameter int DWELL_W     = DEF_DWELL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic               sel_load,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N_CH-1:0]    gate_n,
  output logic [N_CH-1:0]    gate_p,
  output logic [SEL_W-1:0]   active_ch,
  output logic               busy,
  output logic               ch_valid,
  output logic               sel_err
);

  localparam int                DEAD_W    = $clog2(DEAD_CYCLES + 1);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [SEL_W-1:0]  LAST_CH   = SEL_W'(N_CH - 1);

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     target_q, target_d;
  logic [DEAD_W-1:0]    dead_q, dead_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 hold_first_q, hold_first_d;
  logic                 mode_q;
  logic                 sel_ok;
  logic                 load_ok;
  logic                 retarget;
  logic [SEL_W-1:0]     next_ch;

  assign sel_ok   = sel_valid(32'(sel_in), 32'(N_CH));
  assign load_ok  = sel_load && sel_ok;
  assign retarget = load_ok && (sel_in != target_q);
  assign next_ch  = (target_q == LAST_CH) ? '0 : target_q + SEL_W'(1);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    dead_d       = dead_q;
    dwell_d      = dwell_q;
    hold_first_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_ok) begin
          target_d = sel_in;
          state_d  = BREAK;
          dead_d   = DEAD_LOAD;
        end else if (mode) begin
          target_d = '0;
          state_d  = BREAK;
          dead_d   = DEAD_LOAD;
        end
      end
      BREAK: begin
        if (load_ok) target_d = sel_in;
        if (dead_q == '0) begin
          state_d      = HOLD;
          dwell_d      = dwell;
          hold_first_d = 1'b1;
        end else begin
          dead_d = dead_q - DEAD_W'(1);
        end
      end
      HOLD: begin
        if (mode && mode_q) begin
          // Steady scan: on expiry a valid strobe overrides the round-robin step.
          if (dwell_q == '0) begin
            target_d = load_ok ? sel_in : next_ch;
            state_d  = BREAK;
            dead_d   = DEAD_LOAD;
          end else begin
            dwell_d = dwell_q - DWELL_W'(1);
            if (retarget) begin
              target_d = sel_in;
              state_d  = BREAK;
              dead_d   = DEAD_LOAD;
            end
          end
        end else begin
          // Manual hold; entering scan restarts the dwell from this cycle.
          if (mode) dwell_d = dwell;
          if (retarget) begin
            target_d = sel_in;
            state_d  = BREAK;
            dead_d   = DEAD_LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !ena) begin
      state_q      <= IDLE;
      target_q     <= '0;
      dead_q       <= '0;
      dwell_q      <= '0;
      hold_first_q <= 1'b0;
      mode_q       <= 1'b0;
      active_ch    <= '0;
      busy         <= 1'b0;
      ch_valid     <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      dead_q       <= dead_d;
      dwell_q      <= dwell_d;
      hold_first_q <= hold_first_d;
      mode_q       <= mode;
      busy         <= (state_q == BREAK);
      ch_valid     <= (state_q == HOLD) && hold_first_q;
      if (state_q == HOLD) active_ch <= target_q;
    end
  end

  // sel_err keeps reporting bad selects even while the block is disabled.
  always_ff @(posedge clk) begin
    if (rst) sel_err <= 1'b0;
    else     sel_err <= sel_load && !sel_ok;
  end

  mux_gate_decoder #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_gate_decoder (
    .clk    (clk),
    .rst    (rst),
    .en     (ena && (state_q == HOLD)),
    .sel    (target_q),
    .gate_n (gate_n),
    .gate_p (gate_p)
  );

endmodule

// File: tb/tb_analog_mux_sequencer.sv
// Self-checking bench: directed scenarios plus a randomized run against a timeline model.
module tb_analog_mux_sequencer;

  localparam int DEAD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       mode = 1'b0;
  logic [1:0] sel_in = '0;
  logic       sel_load = 1'b0;
  logic [7:0] dwell = '0;

  logic [3:0] gate_n, gate_p;
  logic [1:0] active_ch;
  logic       busy, ch_valid, sel_err;

  logic [2:0] g3_n, g3_p;
  logic [1:0] act3;
  logic       busy3, chv3, err3;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 = all off, 1 = gap, 2 = connected.
  int   m_ph, m_tgt, m_gap_left, m_hold_left;
  bit   m_first, m_prev_mode;
  logic [3:0] e_gate;
  logic [1:0] e_act;
  logic       e_busy, e_chv, e_err;

  always #5 clk = ~clk;

  analog_mux_sequencer #(.N_CH(4), .SEL_W(2), .DEAD_CYCLES(DEAD), .DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .sel_in(sel_in), .sel_load(sel_load),
    .dwell(dwell), .gate_n(gate_n), .gate_p(gate_p), .active_ch(active_ch),
    .busy(busy), .ch_valid(ch_valid), .sel_err(sel_err)
  );

  analog_mux_sequencer #(.N_CH(3), .SEL_W(2), .DEAD_CYCLES(DEAD), .DWELL_W(8)) dut3 (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .sel_in(sel_in), .sel_load(sel_load),
    .dwell(dwell), .gate_n(g3_n), .gate_p(g3_p), .active_ch(act3),
    .busy(busy3), .ch_valid(chv3), .sel_err(err3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ena = 1'b1; mode = 1'b0; sel_load = 1'b0; sel_in = '0; dwell = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic load_sel(input logic [1:0] s);
    sel_in = s; sel_load = 1'b1;
    step();
    sel_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    total++;
    if ({gate_n, gate_p, busy, ch_valid, active_ch, sel_err} !== {4'h0, 4'hF, 1'b0, 1'b0, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values got gn=%b gp=%b busy=%b cv=%b act=%0d err=%b", gate_n, gate_p, busy, ch_valid, active_ch, sel_err);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (gate_n !== 4'h0 || busy !== 1'b0 || gate_p !== 4'hF) begin
        bad++;
        $display("FAIL idle_stays_off cyc=%0d gn=%b gp=%b busy=%b want gn=0000 busy=0", i, gate_n, gate_p, busy);
      end
    end
  endtask

  task automatic test_manual();
    do_reset();
    load_sel(2'd2);
    for (int k = 1; k <= 4; k++) begin
      logic [3:0] wg;
      logic       wb, wc;
      step();
      wg = (k >= 3) ? 4'b0100 : 4'b0000;
      wb = (k < 3);
      wc = (k == 3);
      total++;
      if (gate_n !== wg || busy !== wb || ch_valid !== wc || gate_p !== ~wg) begin
        bad++;
        $display("FAIL manual_latency t+%0d gn=%b busy=%b cv=%b want gn=%b busy=%b cv=%b", k, gate_n, busy, ch_valid, wg, wb, wc);
      end
    end
    total++;
    if (active_ch !== 2'd2) begin
      bad++;
      $display("FAIL manual_active_ch got %0d want 2", active_ch);
    end
  endtask

  task automatic test_scan();
    do_reset();
    mode = 1'b1; dwell = 8'd3;
    step();
    for (int k = 1; k <= 31; k++) begin
      logic [3:0] wg;
      step();
      wg = 4'b0000;
      if (k >= 3 && ((k - 3) % 6) < 4) wg = 4'b0001 << (((k - 3) / 6) % 4);
      total++;
      if (gate_n !== wg || gate_p !== ~gate_n || $countones(gate_n) > 1) begin
        bad++;
        $display("FAIL scan_order k=%0d gn=%b gp=%b want gn=%b", k, gate_n, gate_p, wg);
      end
    end
    mode = 1'b0;
  endtask

  task automatic test_retarget_break();
    bit saw3;
    do_reset();
    load_sel(2'd1);
    repeat (3) step();
    total++;
    if (gate_n !== 4'b0010) begin
      bad++;
      $display("FAIL retarget_setup gn=%b want 0010", gate_n);
    end
    sel_in = 2'd3; sel_load = 1'b1;
    step();
    sel_in = 2'd2;
    step();
    sel_load = 1'b0;
    saw3 = gate_n[3];
    for (int k = 2; k <= 6; k++) begin
      step();
      saw3 |= gate_n[3];
      if (k == 2 || k == 3) begin
        total++;
        if (gate_n !== ((k == 3) ? 4'b0100 : 4'b0000)) begin
          bad++;
          $display("FAIL retarget_gate t+%0d gn=%b want %b", k, gate_n, (k == 3) ? 4'b0100 : 4'b0000);
        end
      end
    end
    total++;
    if (saw3) begin
      bad++;
      $display("FAIL retarget_ch3_enabled got 1 want 0");
    end
  endtask

  task automatic test_invalid_sel();
    do_reset();
    load_sel(2'd1);
    repeat (3) step();
    sel_in = 2'd3; sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    total++;
    if (err3 !== 1'b1 || g3_n !== 3'b010) begin
      bad++;
      $display("FAIL invalid_sel_pulse err=%b gn=%b want err=1 gn=010", err3, g3_n);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (err3 !== 1'b0 || g3_n !== 3'b010 || busy3 !== 1'b0 || g3_p !== 3'b101) begin
        bad++;
        $display("FAIL invalid_sel_hold k=%0d err=%b gn=%b gp=%b busy=%b want 0/010/101/0", k, err3, g3_n, g3_p, busy3);
      end
    end
  endtask

  task automatic test_ena_and_rst();
    do_reset();
    load_sel(2'd2);
    repeat (3) step();
    ena = 1'b0;
    step();
    ena = 1'b1;
    total++;
    if ({gate_n, gate_p, busy, ch_valid, active_ch} !== {4'h0, 4'hF, 1'b0, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL ena_drop gn=%b gp=%b busy=%b cv=%b act=%0d", gate_n, gate_p, busy, ch_valid, active_ch);
    end
    repeat (2) step();
    total++;
    if (gate_n !== 4'h0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ena_back_idle gn=%b busy=%b want 0000/0", gate_n, busy);
    end
    load_sel(2'd1);
    step();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_setup_busy got %b want 1", busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({gate_n, gate_p, busy, ch_valid, active_ch, sel_err} !== {4'h0, 4'hF, 1'b0, 1'b0, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL rst_in_break gn=%b gp=%b busy=%b cv=%b act=%0d err=%b", gate_n, gate_p, busy, ch_valid, active_ch, sel_err);
    end
  endtask

  task automatic model_clear();
    m_ph = 0; m_tgt = 0; m_gap_left = 0; m_hold_left = 0; m_first = 0; m_prev_mode = 0;
  endtask

  task automatic model_gap(input int t);
    m_tgt = t; m_ph = 1; m_gap_left = DEAD;
  endtask

  // Predicts outputs visible after the coming edge from the inputs sampled at it.
  task automatic model_step();
    bit ok;
    if (rst) begin
      model_clear();
      e_gate = '0; e_busy = 0; e_chv = 0; e_act = '0; e_err = 0;
      return;
    end
    e_err = sel_load && (sel_in >= 4);
    if (!ena) begin
      model_clear();
      e_gate = '0; e_busy = 0; e_chv = 0; e_act = '0;
      return;
    end
    e_gate = (m_ph == 2) ? (4'b0001 << m_tgt) : 4'b0000;
    e_busy = (m_ph == 1);
    e_chv  = (m_ph == 2) && m_first;
    if (m_ph == 2) e_act = 2'(m_tgt);
    ok = sel_load && (sel_in < 4);
    if (m_ph == 0) begin
      if (ok) model_gap(int'(sel_in));
      else if (mode) model_gap(0);
    end else if (m_ph == 1) begin
      if (ok) m_tgt = int'(sel_in);
      m_gap_left--;
      if (m_gap_left == 0) begin
        m_ph = 2; m_hold_left = int'(dwell) + 1; m_first = 1;
      end
    end else begin
      m_first = 0;
      if (mode && m_prev_mode) begin
        m_hold_left--;
        if (m_hold_left == 0) model_gap(ok ? int'(sel_in) : (m_tgt + 1) % 4);
        else if (ok && int'(sel_in) != m_tgt) model_gap(int'(sel_in));
      end else begin
        if (mode) m_hold_left = int'(dwell) + 1;
        if (ok && int'(sel_in) != m_tgt) model_gap(int'(sel_in));
      end
    end
    m_prev_mode = mode;
  endtask

  task automatic test_random();
    do_reset();
    model_clear();
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      ena      = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      sel_load = ($urandom_range(0, 6) == 0);
      sel_in   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) dwell = 8'($urandom_range(0, 5));
      model_step();
      step();
      total++;
      if ({gate_n, busy, ch_valid, active_ch, sel_err} !== {e_gate, e_busy, e_chv, e_act, e_err}
          || gate_p !== ~gate_n || $countones(gate_n) > 1) begin
        bad++;
        $display("FAIL random cyc=%0d got gn=%b gp=%b busy=%b cv=%b act=%0d err=%b want gn=%b busy=%b cv=%b act=%0d err=%b",
                 i, gate_n, gate_p, busy, ch_valid, active_ch, sel_err, e_gate, e_busy, e_chv, e_act, e_err);
      end
    end
    rst = 1'b0; ena = 1'b1; sel_load = 1'b0; mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_retarget_break();
    test_invalid_sel();
    test_ena_and_rst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
